// File: rtl/uart_rx_latch_loader.sv
// UART receiver (LSB first, 8 data bits) that turns each good byte into a nibble plus
// active-low save strobes for latch A/B. Define UART_RX_LATCH_PARITY_EN for 8E1 framing.
module uart_rx_latch_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       save_a_n,
  output logic       save_b_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_LATCH_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        rx_meta_reg, rx_s_reg;
  logic [3:0]  data_out_reg, data_out_next;
  logic [7:0]  byte_data_reg, byte_data_next;
  logic        save_a_n_reg, save_a_n_next;
  logic        save_b_n_reg, save_b_n_next;
  logic        byte_valid_reg, byte_valid_next;
  logic        frame_error_reg, frame_error_next;
  logic        parity_bad;
`ifdef UART_RX_LATCH_PARITY_EN
  logic        par_reg, par_next;
  logic        parity_error_reg, parity_error_next;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    data_out_next    = data_out_reg;
    byte_data_next   = byte_data_reg;
    save_a_n_next    = 1'b1;
    save_b_n_next    = 1'b1;
    byte_valid_next  = 1'b0;
    frame_error_next = 1'b0;
    parity_bad       = 1'b0;
`ifdef UART_RX_LATCH_PARITY_EN
    par_next          = par_reg;
    parity_error_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next     = '0;
          bit_idx_next = 3'd0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_s_reg, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_LATCH_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef UART_RX_LATCH_PARITY_EN
      PARITY: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          par_next   = rx_s_reg;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
`ifdef UART_RX_LATCH_PARITY_EN
          parity_bad        = ^{shift_reg, par_reg};
          parity_error_next = parity_bad;
`endif
          if (!rx_s_reg) begin
            frame_error_next = 1'b1;
            state_next       = WAIT_IDLE;
          end else begin
            state_next = IDLE;
            if (!parity_bad) begin
              byte_data_next  = shift_reg;
              byte_valid_next = 1'b1;
              // Field 00 is a plain byte: no strobe, so the latch nibble is left alone.
              if (shift_reg[7:6] != 2'b00) begin
                data_out_next = shift_reg[3:0];
                save_a_n_next = ~shift_reg[6];
                save_b_n_next = ~shift_reg[7];
              end
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      data_out_reg    <= 4'h0;
      byte_data_reg   <= 8'h00;
      save_a_n_reg    <= 1'b1;
      save_b_n_reg    <= 1'b1;
      byte_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
`ifdef UART_RX_LATCH_PARITY_EN
      par_reg          <= 1'b0;
      parity_error_reg <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      data_out_reg    <= data_out_next;
      byte_data_reg   <= byte_data_next;
      save_a_n_reg    <= save_a_n_next;
      save_b_n_reg    <= save_b_n_next;
      byte_valid_reg  <= byte_valid_next;
      frame_error_reg <= frame_error_next;
`ifdef UART_RX_LATCH_PARITY_EN
      par_reg          <= par_next;
      parity_error_reg <= parity_error_next;
`endif
    end
  end

  assign data_out    = data_out_reg;
  assign byte_data   = byte_data_reg;
  assign save_a_n    = save_a_n_reg;
  assign save_b_n    = save_b_n_reg;
  assign byte_valid  = byte_valid_reg;
  assign frame_error = frame_error_reg;
`ifdef UART_RX_LATCH_PARITY_EN
  assign parity_error = parity_error_reg;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_latch_loader.sv
// Bench for uart_rx_latch_loader: directed and random frames checked against a byte-level
// model of the load rules and the frame-to-strobe latency.
module tb_uart_rx_latch_loader;

  localparam int C = 16;
`ifdef UART_RX_LATCH_PARITY_EN
  localparam int LAT = 3 + C / 2 + 10 * C;
`else
  localparam int LAT = 3 + C / 2 + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] data_out;
  logic       save_a_n, save_b_n, byte_valid, frame_error, parity_error;
  logic [7:0] byte_data;

  uart_rx_latch_loader #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(data_out), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_error(frame_error), .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int n_valid, n_a, n_b, n_ferr, n_perr, dout_glitch;
  int valid_cyc, strobe_cyc, ferr_cyc, perr_cyc, t0;
  logic [7:0] valid_byte;
  logic [3:0] strobe_data, prev_dout;
  logic [3:0] model_dout = 4'h0;
  logic [7:0] model_bdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_valid = 0; n_a = 0; n_b = 0; n_ferr = 0; n_perr = 0; dout_glitch = 0;
    valid_cyc = -1; strobe_cyc = -1; ferr_cyc = -1; perr_cyc = -1;
    valid_byte = 8'h00; strobe_data = 4'h0;
    prev_dout = data_out;
  endtask

  // One bit-clock of line drive; outputs are observed mid-cycle after the edge.
  task automatic tick(input logic v);
    rx = v;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (byte_valid) begin n_valid++; valid_cyc = cyc; valid_byte = byte_data; end
    if (!save_a_n) n_a++;
    if (!save_b_n) n_b++;
    if (!save_a_n || !save_b_n) begin strobe_cyc = cyc; strobe_data = data_out; end
    if (frame_error) begin n_ferr++; ferr_cyc = cyc; end
    if (parity_error) begin n_perr++; perr_cyc = cyc; end
    if (data_out !== prev_dout && save_a_n && save_b_n) dout_glitch++;
    prev_dout = data_out;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input int stop_low_bits,
                            output int start_cyc);
    start_cyc = cyc + 1;
    repeat (C) tick(1'b0);
    for (int i = 0; i < 8; i++) repeat (C) tick(b[i]);
`ifdef UART_RX_LATCH_PARITY_EN
    repeat (C) tick(par);
`endif
    repeat (stop_low_bits * C) tick(1'b0);
    repeat (C) tick(1'b1);
  endtask

  task automatic good_frame(input logic [7:0] b, input int gap);
    int exp_a, exp_b;
    repeat (gap) tick(1'b1);
    clear_obs();
    send_frame(b, ^b, 0, t0);
    // Reference: top two bits pick the target latch(es); 00 means no load.
    case (b[7:6])
      2'b01:   begin exp_a = 1; exp_b = 0; end
      2'b10:   begin exp_a = 0; exp_b = 1; end
      2'b11:   begin exp_a = 1; exp_b = 1; end
      default: begin exp_a = 0; exp_b = 0; end
    endcase
    if (exp_a + exp_b > 0) model_dout = b[3:0];
    model_bdata = b;
    $display("frame %02h: valid=%0d a=%0d b=%0d data_out=%h lat=%0d", b, n_valid, n_a, n_b,
             data_out, valid_cyc - t0);
    chk("valid_cnt", 32'(n_valid), 32'd1);
    chk("valid_latency", 32'(valid_cyc - t0), 32'(LAT));
    chk("byte_data_pulse", 32'(valid_byte), 32'(b));
    chk("byte_data_hold", 32'(byte_data), 32'(model_bdata));
    chk("save_a_cnt", 32'(n_a), 32'(exp_a));
    chk("save_b_cnt", 32'(n_b), 32'(exp_b));
    chk("data_out", 32'(data_out), 32'(model_dout));
    chk("frame_err_cnt", 32'(n_ferr), 32'd0);
    chk("parity_err_cnt", 32'(n_perr), 32'd0);
    chk("dout_no_strobe_change", 32'(dout_glitch), 32'd0);
    if (exp_a + exp_b > 0) begin
      chk("strobe_latency", 32'(strobe_cyc - t0), 32'(LAT));
      chk("strobe_data", 32'(strobe_data), 32'(b[3:0]));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("reset: data_out=%h byte_data=%h a=%b b=%b", data_out, byte_data, save_a_n, save_b_n);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_save_a_n", 32'(save_a_n), 32'd1);
    chk("rst_save_b_n", 32'(save_b_n), 32'd1);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_parity_error", 32'(parity_error), 32'd0);
    reset = 1'b0;
    repeat (5) tick(1'b1);

    good_frame(8'h45, 0);
    good_frame(8'h07, 3);
    good_frame(8'h8A, 2);
    good_frame(8'hC3, 0);

    // Stop bit held low for three bit periods.
    clear_obs();
    send_frame(8'h45, ^8'h45, 3, t0);
    repeat (4) tick(1'b1);
    $display("framing error frame: ferr=%0d valid=%0d a=%0d b=%0d", n_ferr, n_valid, n_a, n_b);
    chk("ferr_cnt", 32'(n_ferr), 32'd1);
    chk("ferr_latency", 32'(ferr_cyc - t0), 32'(LAT));
    chk("ferr_valid_cnt", 32'(n_valid), 32'd0);
    chk("ferr_strobe_cnt", 32'(n_a + n_b), 32'd0);
    chk("ferr_data_out", 32'(data_out), 32'(model_dout));
    chk("ferr_byte_data", 32'(byte_data), 32'(model_bdata));
    good_frame(8'h81, 0);

    // Short low glitch must be ignored.
    clear_obs();
    repeat (4) tick(1'b0);
    repeat (20) tick(1'b1);
    $display("glitch: valid=%0d strobes=%0d ferr=%0d", n_valid, n_a + n_b, n_ferr);
    chk("glitch_valid_cnt", 32'(n_valid), 32'd0);
    chk("glitch_strobe_cnt", 32'(n_a + n_b), 32'd0);
    chk("glitch_ferr_cnt", 32'(n_ferr), 32'd0);
    chk("glitch_data_out", 32'(data_out), 32'(model_dout));

    // Reset five bit periods into a 0x45 frame.
    clear_obs();
    repeat (C) tick(1'b0);
    for (int i = 0; i < 4; i++) repeat (C) tick(i[0] ? 1'b0 : 1'b1);
    reset = 1'b1;
    #1;
    $display("mid-frame reset: data_out=%h byte_data=%h", data_out, byte_data);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_byte_data", 32'(byte_data), 32'd0);
    chk("midrst_save_a_n", 32'(save_a_n), 32'd1);
    chk("midrst_save_b_n", 32'(save_b_n), 32'd1);
    chk("midrst_byte_valid", 32'(byte_valid), 32'd0);
    repeat (3) tick(1'b1);
    reset = 1'b0;
    repeat (20) tick(1'b1);
    chk("midrst_valid_cnt", 32'(n_valid), 32'd0);
    chk("midrst_strobe_cnt", 32'(n_a + n_b), 32'd0);
    chk("midrst_ferr_cnt", 32'(n_ferr), 32'd0);
    model_dout = 4'h0;
    model_bdata = 8'h00;
    good_frame(8'h42, 0);

`ifdef UART_RX_LATCH_PARITY_EN
    clear_obs();
    send_frame(8'h45, 1'b0, 0, t0);
    repeat (4) tick(1'b1);
    $display("bad parity: perr=%0d valid=%0d strobes=%0d", n_perr, n_valid, n_a + n_b);
    chk("perr_cnt", 32'(n_perr), 32'd1);
    chk("perr_latency", 32'(perr_cyc - t0), 32'(LAT));
    chk("perr_valid_cnt", 32'(n_valid), 32'd0);
    chk("perr_strobe_cnt", 32'(n_a + n_b), 32'd0);
    chk("perr_data_out", 32'(data_out), 32'(model_dout));
    good_frame(8'h45, 0);
`endif

    for (int k = 0; k < 8; k++) good_frame(8'($urandom), int'($urandom_range(0, 12)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
